cmos_frame_scheduler: RTL and testbench

Frame-boundary scheduler that decides which camera (cmos1 or cmos2) feeds the Ethernet video path and when that path is enabled. It runs on sys_clk and synchronises both camera vsync signals. It accepts mode commands from the UART receiver and drives the select and gate inputs of the camera channel multiplexer. Channel changes happen only between frames, and only when the Ethernet transmitter is idle, so no torn frame is ever sent.

---
 rtl/cmos_frame_scheduler_if.sv | 15 +
 rtl/cmos_frame_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_cmos_frame_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cmos_frame_scheduler_if.sv
// Command / mux-control bundle between the UART decoder, Ethernet TX and the frame scheduler.
// The master side issues commands and reports TX activity; the slave (scheduler) drives the mux controls.
interface cmos_frame_scheduler_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       tx_busy;
    logic       sel;
    logic       gate;
    logic       frame_start;

    modport master (output cmd_valid, cmd_data, tx_busy,
                    input  sel, gate, frame_start);
    modport slave  (input  cmd_valid, cmd_data, tx_busy,
                    output sel, gate, frame_start);
endinterface

// File: rtl/cmos_frame_scheduler.sv
// Frame-boundary camera scheduler: picks cmos1/cmos2 for the Ethernet video path, switching only between frames.
// Optional per-camera vsync watchdog is compiled in with SCHED_WATCHDOG_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// INIT     | waiting for any camera to finish register configuration
// SWITCH   | gate off, waiting for TX idle, then loading the target sel
// WAIT_VS  | gate off, waiting for the selected camera's frame start
// STREAM   | gate on, forwarding frames of the selected camera
// STOP     | gate off until a non-stop command arrives
module cmos_frame_scheduler #(
    parameter logic [1:0]  DEFAULT_MODE  = 2'd1,
    parameter logic [7:0]  ALT_FRAMES    = 8'd1,
    parameter logic [31:0] FRAME_TIMEOUT = 32'd10_000_000
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [1:0]                    cmos_init_done,
    input  logic                          cmos1_vsync,
    input  logic                          cmos2_vsync,
    cmos_frame_scheduler_if.slave         bus,
    output logic [1:0]                    mode,
    output logic [1:0]                    cam_lost,
    output logic [15:0]                   frame_cnt
);
    typedef enum logic [2:0] {ST_INIT, ST_SWITCH, ST_WAIT_VS, ST_STREAM, ST_STOP} state_t;

    localparam logic [1:0] M_STOP = 2'd0;
    localparam logic [1:0] M_CAM1 = 2'd1;
    localparam logic [1:0] M_CAM2 = 2'd2;
    localparam logic [1:0] M_ALT  = 2'd3;

    state_t      state, state_nx;
    logic [1:0]  vs_meta, vs_sync, vs_dly, vs_edge;
    logic [1:0]  mode_q, mode_nx, pend_mode, pend_nx;
    logic [7:0]  alt_cnt, alt_nx, alt_inc;
    logic        sel_q, sel_nx, gate_q, start_q, start_nx;
    logic [15:0] frame_cnt_q;
    logic [1:0]  eligible;
    logic        cur_ok, other_ok, boundary, lost_skip, wrong_cam, cmd_ok;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            vs_meta <= '0;
            vs_sync <= '0;
            vs_dly  <= '0;
        end else begin
            vs_meta <= {cmos2_vsync, cmos1_vsync};
            vs_sync <= vs_meta;
            vs_dly  <= vs_sync;
        end
    end
    assign vs_edge = vs_sync & ~vs_dly;

`ifdef SCHED_WATCHDOG_EN
    logic [1:0][31:0] wd_cnt;
    logic [1:0]       lost_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wd_cnt <= {FRAME_TIMEOUT, FRAME_TIMEOUT};
            lost_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (vs_edge[i]) begin
                    wd_cnt[i] <= FRAME_TIMEOUT;
                    lost_q[i] <= 1'b0;
                end else if (wd_cnt[i] != 32'd0) begin
                    wd_cnt[i] <= wd_cnt[i] - 32'd1;
                    if (wd_cnt[i] == 32'd1) lost_q[i] <= 1'b1;
                end
            end
        end
    end
    assign cam_lost = lost_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^FRAME_TIMEOUT;
    assign cam_lost       = 2'b00;
`endif

    assign eligible = cmos_init_done & ~cam_lost;
    assign cur_ok   = sel_q ? eligible[1] : eligible[0];
    assign other_ok = sel_q ? eligible[0] : eligible[1];
    assign boundary = sel_q ? vs_edge[1] : vs_edge[0];

    // A command in the same cycle as a boundary is already visible through pend_nx.
    assign cmd_ok    = bus.cmd_valid && (bus.cmd_data[7:2] == 6'd0);
    assign pend_nx   = cmd_ok ? bus.cmd_data[1:0] : pend_mode;
    assign wrong_cam = ((pend_nx == M_CAM1) && sel_q) || ((pend_nx == M_CAM2) && !sel_q);
    assign lost_skip = (mode_q == M_ALT) && !cur_ok && other_ok;
    assign alt_inc   = (alt_cnt == 8'hFF) ? alt_cnt : alt_cnt + 8'd1;

    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        mode_nx  = mode_q;
        alt_nx   = alt_cnt;
        start_nx = 1'b0;
        case (state)
            ST_INIT: begin
                if (cmos_init_done != 2'b00) begin
                    state_nx = ST_SWITCH;
                    mode_nx  = pend_nx;
                end
            end
            ST_SWITCH: begin
                if (!bus.tx_busy) begin
                    alt_nx   = '0;
                    state_nx = ST_WAIT_VS;
                    case (mode_q)
                        M_STOP:  state_nx = ST_STOP;
                        M_CAM1:  sel_nx = 1'b0;
                        M_CAM2:  sel_nx = 1'b1;
                        default: if (other_ok) sel_nx = ~sel_q;
                    endcase
                end
            end
            ST_WAIT_VS: begin
                if (lost_skip) begin
                    state_nx = ST_SWITCH;
                    mode_nx  = pend_nx;
                end else if (boundary && cur_ok) begin
                    mode_nx = pend_nx;
                    if (pend_nx == M_STOP) begin
                        state_nx = ST_STOP;
                    end else if (wrong_cam) begin
                        state_nx = ST_SWITCH;
                    end else begin
                        state_nx = ST_STREAM;
                        start_nx = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (lost_skip) begin
                    state_nx = ST_SWITCH;
                    mode_nx  = pend_nx;
                end else if (boundary) begin
                    mode_nx = pend_nx;
                    alt_nx  = alt_inc;
                    if (pend_nx == M_STOP) begin
                        state_nx = ST_STOP;
                    end else if (wrong_cam || ((pend_nx == M_ALT) && (alt_inc >= ALT_FRAMES))) begin
                        state_nx = ST_SWITCH;
                    end else begin
                        start_nx = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (pend_nx != M_STOP) begin
                    state_nx = ST_SWITCH;
                    mode_nx  = pend_nx;
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state       <= ST_INIT;
            sel_q       <= 1'b0;
            gate_q      <= 1'b0;
            start_q     <= 1'b0;
            mode_q      <= DEFAULT_MODE;
            pend_mode   <= DEFAULT_MODE;
            alt_cnt     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state     <= state_nx;
            sel_q     <= sel_nx;
            gate_q    <= (state_nx == ST_STREAM);
            start_q   <= start_nx;
            mode_q    <= mode_nx;
            pend_mode <= pend_nx;
            alt_cnt   <= alt_nx;
            if (start_nx) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.gate        = gate_q;
    assign bus.frame_start = start_q;
    assign mode            = mode_q;
    assign frame_cnt       = frame_cnt_q;
endmodule

// File: tb/tb_cmos_frame_scheduler.sv
// Directed bench for cmos_frame_scheduler: expected camera of each forwarded frame is queued
// as vsyncs are driven and checked when frame_start fires.
module tb_cmos_frame_scheduler;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [1:0]  cmos_init_done = 2'b00;
    logic        cmos1_vsync = 1'b0;
    logic        cmos2_vsync = 1'b0;
    logic [1:0]  mode;
    logic [1:0]  cam_lost;
    logic [15:0] frame_cnt;

    cmos_frame_scheduler_if bus ();

    cmos_frame_scheduler #(
        .DEFAULT_MODE  (2'd1),
        .ALT_FRAMES    (8'd2),
        .FRAME_TIMEOUT (32'd5000)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .cmos_init_done (cmos_init_done),
        .cmos1_vsync    (cmos1_vsync),
        .cmos2_vsync    (cmos2_vsync),
        .bus            (bus.slave),
        .mode           (mode),
        .cam_lost       (cam_lost),
        .frame_cnt      (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int   checks = 0;
    int   errors = 0;
    int   seen = 0;
    int   free_frames = 0;
    bit   free_run = 1'b0;
    bit   free_chk = 1'b0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge sys_clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        @(posedge sys_clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
    endtask

    task automatic pulse(input int cam, input int gap);
        @(posedge sys_clk); #1;
        if (cam == 0) cmos1_vsync = 1'b1;
        else          cmos2_vsync = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        cmos1_vsync = 1'b0;
        cmos2_vsync = 1'b0;
        repeat (gap) @(posedge sys_clk);
        #1;
    endtask

    // Forwarded-frame monitor
    always @(negedge sys_clk) begin
        if (sys_rst && bus.frame_start === 1'b1) begin
            seen++;
            chk("frame_cnt", 32'(frame_cnt), 32'(seen));
            chk("gate_at_start", 32'(bus.gate), 32'd1);
            if (free_run) begin
                if (free_chk) begin
                    free_frames++;
                    chk("lost_skip_sel", 32'(bus.sel), 32'd0);
                end
            end else begin
                chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("frame_sel", 32'(bus.sel), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic bad;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.tx_busy   = 1'b0;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_gate", 32'(bus.gate), 32'd0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        chk("rst_mode", 32'(mode), 32'd1);
        chk("rst_cam_lost", 32'(cam_lost), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        sys_rst = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        chk("init_gate", 32'(bus.gate), 32'd0);
        cmos_init_done = 2'b11;
        repeat (5) @(posedge sys_clk);

        // first cam1 frame: gate exactly one cycle after vs_edge
        exp_q.push_back(1'b0);
        @(posedge sys_clk); #1;
        cmos1_vsync = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("gate_lat_early", 32'(bus.gate), 32'd0);
        @(posedge sys_clk); #1;
        chk("gate_lat", 32'(bus.gate), 32'd1);
        repeat (2) @(posedge sys_clk);
        #1;
        cmos1_vsync = 1'b0;
        repeat (20) @(posedge sys_clk);

        pulse(1, 20);
        exp_q.push_back(1'b0); pulse(0, 20);
        exp_q.push_back(1'b0); pulse(0, 20);
        chk("cnt_after_3", 32'(frame_cnt), 32'd3);
        chk("sel_cam1", 32'(bus.sel), 32'd0);

        // switch to cam2 mid-frame
        send_cmd(8'h02);
        chk("mid_gate", 32'(bus.gate), 32'd1);
        chk("mid_mode", 32'(mode), 32'd1);
        pulse(0, 20);
        chk("sw_gate", 32'(bus.gate), 32'd0);
        chk("sw_mode", 32'(mode), 32'd2);
        chk("sw_sel", 32'(bus.sel), 32'd1);
        exp_q.push_back(1'b1); pulse(1, 20);
        chk("cam2_gate", 32'(bus.gate), 32'd1);

        // switch held off by tx_busy
        bus.tx_busy = 1'b1;
        send_cmd(8'h01);
        pulse(1, 10);
        chk("busy_mode", 32'(mode), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge sys_clk); #1;
            if (bus.gate !== 1'b0 || bus.sel !== 1'b1) bad = 1'b1;
        end
        chk("busy_hold", 32'(bad), 32'd0);
        bus.tx_busy = 1'b0;
        chk("busy_sel_before", 32'(bus.sel), 32'd1);
        @(posedge sys_clk); #1;
        chk("busy_sel_after", 32'(bus.sel), 32'd0);
        chk("busy_gate_after", 32'(bus.gate), 32'd0);
        exp_q.push_back(1'b0); pulse(0, 20);

        // alternate, two frames per camera
        send_cmd(8'h03);
        exp_q.push_back(1'b0); pulse(0, 20);
        pulse(0, 20);
        chk("alt_sel2", 32'(bus.sel), 32'd1);
        pulse(0, 20);
        exp_q.push_back(1'b1); pulse(1, 20);
        exp_q.push_back(1'b1); pulse(1, 20);
        pulse(1, 20);
        chk("alt_sel1", 32'(bus.sel), 32'd0);
        exp_q.push_back(1'b0); pulse(0, 20);

        // stop, ignored byte, resume
        send_cmd(8'h00);
        pulse(0, 20);
        chk("stop_mode", 32'(mode), 32'd0);
        chk("stop_gate", 32'(bus.gate), 32'd0);
        send_cmd(8'h7F);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("bad_cmd_mode", 32'(mode), 32'd0);
        pulse(0, 20);
        send_cmd(8'h01);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("resume_mode", 32'(mode), 32'd1);
        chk("resume_gate", 32'(bus.gate), 32'd0);
        exp_q.push_back(1'b0); pulse(0, 20);
        chk("resume_stream", 32'(bus.gate), 32'd1);

`ifdef SCHED_WATCHDOG_EN
        send_cmd(8'h03);
        free_run = 1'b1;
        repeat (14) pulse(0, 400);
        chk("lost_flag", 32'(cam_lost), 32'd2);
        free_chk = 1'b1;
        repeat (6) pulse(0, 100);
        chk("lost_frames_seen", 32'(free_frames > 0), 32'd1);
        free_chk = 1'b0;
        pulse(1, 20);
        chk("lost_clear", 32'(cam_lost), 32'd0);
`else
        repeat (200) @(posedge sys_clk);
        #1;
        chk("no_watchdog_lost", 32'(cam_lost), 32'd0);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-cycle
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
        #1;
        chk("async_rst_gate", 32'(bus.gate), 32'd0);
        chk("async_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("async_rst_mode", 32'(mode), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
